// File: rtl/pilha_pkg.sv
// Shared types for the return-address / data stack: default sizes and the {push,pop} decode.
package pilha_pkg;

    localparam int WIDTH_PADRAO = 32;
    localparam int DEPTH_PADRAO = 16;

    typedef logic [WIDTH_PADRAO-1:0] word_t;

    typedef enum logic [1:0] {
        OP_NADA  = 2'b00,
        OP_POP   = 2'b01,
        OP_PUSH  = 2'b10,
        OP_TROCA = 2'b11
    } op_t;

    function automatic op_t decodifica(input logic push, input logic pop);
        return op_t'({push, pop});
    endfunction

endpackage

// File: rtl/pilha_borda.sv
// Rising-edge detector for one control request; used only when PILHA_BORDA_EN is defined.
module pilha_borda (
    input  logic clk,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic anterior;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) anterior <= 1'b0;
        else       anterior <= sinal;
    end

    // Only the first posedge of a held request acts.
    assign pulso = sinal & ~anterior;

endmodule

// File: rtl/pilha_enderecos.sv
// Hardware LIFO for return addresses and stack data, top read combinationally.
// Optional macro PILHA_BORDA_EN makes push/pop act on their rising edge only.
import pilha_pkg::*;

module pilha_enderecos #(
    parameter int WIDTH = WIDTH_PADRAO,
    parameter int DEPTH = DEPTH_PADRAO,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] dado_in,
    output logic [WIDTH-1:0] topo,
    output logic [PTR_W-1:0] nivel,
    output logic             vazia,
    output logic             cheia,
    output logic             erro
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] nivel_q;
    logic [PTR_W-1:0] nivel_prox;
    logic [PTR_W-1:0] topo_ptr;
    logic             erro_q;
    logic             erro_set;
    logic             escreve;
    logic [IDX_W-1:0] end_escrita;
    logic             push_ef;
    logic             pop_ef;
    op_t              op;

`ifdef PILHA_BORDA_EN
    pilha_borda u_borda_push (
        .clk   (clk),
        .reset (reset),
        .sinal (push),
        .pulso (push_ef)
    );

    pilha_borda u_borda_pop (
        .clk   (clk),
        .reset (reset),
        .sinal (pop),
        .pulso (pop_ef)
    );
`else
    assign push_ef = push;
    assign pop_ef  = pop;
`endif

    assign topo_ptr = nivel_q - PTR_W'(1);
    assign vazia    = (nivel_q == '0);
    assign cheia    = (nivel_q == PTR_W'(DEPTH));
    assign nivel    = nivel_q;
    assign erro     = erro_q;
    assign topo     = vazia ? '0 : mem[topo_ptr[IDX_W-1:0]];

    // Illegal operations are dropped, so nivel never wraps.
    always_comb begin
        op          = decodifica(push_ef, pop_ef);
        escreve     = 1'b0;
        end_escrita = nivel_q[IDX_W-1:0];
        nivel_prox  = nivel_q;
        erro_set    = 1'b0;
        case (op)
            OP_PUSH: begin
                if (cheia) begin
                    erro_set = 1'b1;
                end else begin
                    escreve    = 1'b1;
                    nivel_prox = nivel_q + PTR_W'(1);
                end
            end
            OP_POP: begin
                if (vazia) erro_set = 1'b1;
                else       nivel_prox = topo_ptr;
            end
            OP_TROCA: begin
                escreve = 1'b1;
                if (vazia) nivel_prox = nivel_q + PTR_W'(1);
                else       end_escrita = topo_ptr[IDX_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nivel_q <= '0;
            erro_q  <= 1'b0;
        end else begin
            nivel_q <= nivel_prox;
            if (erro_set) erro_q <= 1'b1;
        end
    end

    // Storage is not cleared by reset, but a write on a reset edge is suppressed.
    always_ff @(posedge clk) begin
        if (!reset && escreve) mem[end_escrita] <= dado_in;
    end

endmodule

// File: tb/tb_pilha_enderecos.sv
// Directed self-checking bench for pilha_enderecos; expectations follow PILHA_BORDA_EN when defined.
module tb_pilha_enderecos;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] dado_in;
    logic [WIDTH-1:0] topo;
    logic [PTR_W-1:0] nivel;
    logic             vazia;
    logic             cheia;
    logic             erro;

    int checks;
    int errors;

    pilha_enderecos #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .dado_in (dado_in),
        .topo    (topo),
        .nivel   (nivel),
        .vazia   (vazia),
        .cheia   (cheia),
        .erro    (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        p;
        logic        q;
        logic [31:0] d;
        int          e_nivel;
        logic [31:0] e_topo;
        logic        e_erro;
    } vetor_t;

    vetor_t tab [9];

    task automatic chk(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nome, atual, esperado);
        end
    endtask

    task automatic chk_estado(input string nome, input int e_nivel, input logic [31:0] e_topo,
                              input logic e_erro);
        chk({nome, ".nivel"}, 64'(nivel), 64'(e_nivel));
        chk({nome, ".topo"},  64'(topo),  64'(e_topo));
        chk({nome, ".erro"},  64'(erro),  64'(e_erro));
        chk({nome, ".vazia"}, 64'(vazia), 64'(e_nivel == 0));
        chk({nome, ".cheia"}, 64'(cheia), 64'(e_nivel == DEPTH));
    endtask

    // One operation for one edge, followed by an idle edge so edge-mode sees a fresh rise.
    task automatic op1(input logic p, input logic q, input logic [31:0] d);
        @(negedge clk);
        push = p; pop = q; dado_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic ocioso();
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic reinicia();
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        push = 1'b0; pop = 1'b0; dado_in = '0;
        reset = 1'b1;

        tab[0] = '{1'b1, 1'b0, 32'h10, 1, 32'h10, 1'b0};
        tab[1] = '{1'b1, 1'b0, 32'h20, 2, 32'h20, 1'b0};
        tab[2] = '{1'b1, 1'b0, 32'h30, 3, 32'h30, 1'b0};
        tab[3] = '{1'b0, 1'b1, 32'h0,  2, 32'h20, 1'b0};
        tab[4] = '{1'b1, 1'b1, 32'h99, 2, 32'h99, 1'b0};
        tab[5] = '{1'b0, 1'b1, 32'h0,  1, 32'h10, 1'b0};
        tab[6] = '{1'b0, 1'b1, 32'h0,  0, 32'h0,  1'b0};
        tab[7] = '{1'b0, 1'b1, 32'h0,  0, 32'h0,  1'b1};
        tab[8] = '{1'b1, 1'b0, 32'h5,  1, 32'h5,  1'b1};

        #12 reset = 1'b0;
        chk_estado("reset_inicial", 0, 32'h0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            op1(tab[i].p, tab[i].q, tab[i].d);
            chk_estado($sformatf("vetor%0d", i), tab[i].e_nivel, tab[i].e_topo, tab[i].e_erro);
            ocioso();
        end

        // Asynchronous reset mid-cycle, checked before any clock edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_estado("reset_assincrono", 0, 32'h0, 1'b0);
        #1 reset = 1'b0;

        // Simultaneous push+pop on empty acts as a push.
        op1(1'b1, 1'b1, 32'h7);
        chk_estado("troca_vazia", 1, 32'h7, 1'b0);
        ocioso();

        // Fill to DEPTH, then overflow.
        reinicia();
        for (int i = 1; i <= DEPTH; i++) begin
            op1(1'b1, 1'b0, 32'(i));
            chk($sformatf("enche%0d.nivel", i), 64'(nivel), 64'(i));
            chk($sformatf("enche%0d.topo", i),  64'(topo),  64'(i));
            ocioso();
        end
        chk_estado("cheia", DEPTH, 32'(DEPTH), 1'b0);
        op1(1'b1, 1'b0, 32'hFF);
        chk_estado("overflow", DEPTH, 32'(DEPTH), 1'b1);
        ocioso();

        // Reset asserted across a push edge wins.
        @(negedge clk);
        push = 1'b1; dado_in = 32'hAB; reset = 1'b1;
        @(posedge clk);
        #1 chk_estado("reset_vence_push", 0, 32'h0, 1'b0);
        @(negedge clk);
        push = 1'b0; reset = 1'b0;

        // Return-address flow: jal pushes 0x42, then pop held for three cycles.
        op1(1'b1, 1'b0, 32'h11);
        ocioso();
        @(negedge clk);
        push = 1'b1; pop = 1'b0; dado_in = 32'h42;
        @(negedge clk);
        push = 1'b0; pop = 1'b1;
        #1 chk("ra_topo_antes_pop", 64'(topo), 64'h42);
        chk("ra_nivel_antes_pop", 64'(nivel), 64'd2);
        @(posedge clk);
        #1 chk_estado("ra_pop1", 1, 32'h11, 1'b0);
        @(posedge clk);
`ifdef PILHA_BORDA_EN
        #1 chk_estado("ra_pop2", 1, 32'h11, 1'b0);
        @(posedge clk);
        #1 chk_estado("ra_pop3", 1, 32'h11, 1'b0);
`else
        #1 chk_estado("ra_pop2", 0, 32'h0, 1'b0);
        @(posedge clk);
        #1 chk_estado("ra_pop3", 0, 32'h0, 1'b1);
`endif
        @(negedge clk);
        pop = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
